gs_sweep_scheduler: RTL

Sequencing controller for the Gauss-Seidel machine's single shared row-update core. On a start command it loads an initial 8-entry solution vector and issues the 8 row updates of each sweep in order (row 0..7). Each result is written back immediately, so later rows see fresh values. It repeats for a programmed number of sweeps, or stops early when a sweep's largest update magnitude falls below a tolerance. It sits between the top-level load/start logic and the row core, and owns the x register file.

---
 rtl/gs_sweep_scheduler_if.sv | 33 +++
 rtl/gs_sweep_scheduler.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gs_sweep_scheduler_if.sv
// ----------------------------------------------------------------------------
// gs_sweep_scheduler_if
// Issue/result channel between the Gauss-Seidel sweep scheduler (master) and
// the shared row-update core (slave).
//   o_core_valid : one-cycle issue strobe, scheduler -> core
//   o_core_row   : row being issued/awaited
//   o_core_x     : current x without row o_core_row, ascending index, lowest
//                  index at MSBs
//   o_core_xold  : current x[o_core_row]
//   i_core_valid : result strobe, core -> scheduler
//   i_core_x     : result x_next for the awaited row
// ----------------------------------------------------------------------------
interface gs_sweep_scheduler_if #(
  parameter int N_ROW = 8,
  parameter int W_X   = 32
);
  logic                       o_core_valid;
  logic [2:0]                 o_core_row;
  logic [(N_ROW-1)*W_X-1:0]   o_core_x;
  logic [W_X-1:0]             o_core_xold;
  logic                       i_core_valid;
  logic [W_X-1:0]             i_core_x;

  modport master (
    output o_core_valid, o_core_row, o_core_x, o_core_xold,
    input  i_core_valid, i_core_x
  );

  modport slave (
    input  o_core_valid, o_core_row, o_core_x, o_core_xold,
    output i_core_valid, i_core_x
  );
endinterface

// File: rtl/gs_sweep_scheduler.sv
// ----------------------------------------------------------------------------
// gs_sweep_scheduler
// Sequences the shared row-update core through Gauss-Seidel sweeps. Owns the
// 8-entry x register file; each core result is written back at once so later
// rows of the same sweep see fresh values. Stops after the sweep limit or when
// a sweep's largest update magnitude falls below the tolerance.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : start request (IDLE only), captures i_iter/i_tol/i_x
//   i_iter         : sweep limit, 0 treated as 1
//   i_tol          : unsigned convergence threshold, 0 disables early stop
//   i_x            : initial vector, x0 at MSBs
//   core           : issue/result channel to the row core (master side)
//   o_busy         : high in every state except IDLE
//   o_x            : final vector, x0 at MSBs, held until the next run ends
//   o_valid        : one-cycle done pulse
//   o_iters        : sweeps completed in the last run
//   o_converged    : last run ended on tolerance
// ----------------------------------------------------------------------------
module gs_sweep_scheduler #(
  parameter int N_ROW = 8,
  parameter int W_X   = 32,
  parameter int W_IT  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [W_IT-1:0]        i_iter,
  input  logic [W_X-1:0]         i_tol,
  input  logic [N_ROW*W_X-1:0]   i_x,
  gs_sweep_scheduler_if.master   core,
  output logic                   o_busy,
  output logic [N_ROW*W_X-1:0]   o_x,
  output logic                   o_valid,
  output logic [W_IT-1:0]        o_iters,
  output logic                   o_converged
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state;
  logic [W_X-1:0]        x_q [N_ROW];
  logic [2:0]            row_q;
  logic [W_IT-1:0]       limit_q;
  logic [W_IT-1:0]       sweep_q;
  logic [W_X-1:0]        tol_q;
  logic [W_X-1:0]        max_q;

  logic signed [W_X:0]   diff;
  logic [W_X:0]          mag;
  logic [W_X-1:0]        delta;
  logic [W_X-1:0]        max_next;
  logic [W_IT-1:0]       sweep_next;
  logic [N_ROW*W_X-1:0]  x_final;
  logic [2:0]            idx;

  // Update magnitude, sweep-max and saturating sweep count for the row in
  // flight; only consumed when a result is accepted in WAIT.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    diff       = $signed({core.i_core_x[W_X-1], core.i_core_x})
               - $signed({x_q[row_q][W_X-1], x_q[row_q]});
    mag        = diff[W_X] ? $unsigned(-diff) : $unsigned(diff);
    delta      = mag[W_X] ? '1 : mag[W_X-1:0];
    max_next   = (delta > max_q) ? delta : max_q;
    sweep_next = (sweep_q == '1) ? sweep_q : sweep_q + 1'b1;
  end

  // Vector as it will look after the pending write, so o_x is valid in the
  // same cycle as o_valid.
  always_comb begin
    x_final = '0;
    for (int i = 0; i < N_ROW; i++) begin
      x_final[(N_ROW-1-i)*W_X +: W_X] = (3'(i) == row_q) ? core.i_core_x : x_q[i];
    end
  end

  // Operand vector for the core: x with the current row squeezed out.
  always_comb begin
    core.o_core_x = '0;
    idx           = '0;
    for (int i = 0; i < N_ROW-1; i++) begin
      idx = (3'(i) < row_q) ? 3'(i) : 3'(i+1);
      core.o_core_x[(N_ROW-2-i)*W_X +: W_X] = x_q[idx];
    end
  end

  assign core.o_core_row  = row_q;
  assign core.o_core_xold = x_q[row_q];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= S_IDLE;
      // NOTE: the x file is reset because its contents drive o_core_x and
      // o_core_xold, which must read zero out of reset.
      for (int i = 0; i < N_ROW; i++) x_q[i] <= '0;
      row_q             <= '0;
      limit_q           <= '0;
      sweep_q           <= '0;
      tol_q             <= '0;
      max_q             <= '0;
      core.o_core_valid <= 1'b0;
      o_busy            <= 1'b0;
      o_x               <= '0;
      o_valid           <= 1'b0;
      o_iters           <= '0;
      o_converged       <= 1'b0;
    end else begin
      core.o_core_valid <= 1'b0;
      o_valid           <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            for (int i = 0; i < N_ROW; i++) x_q[i] <= i_x[(N_ROW-1-i)*W_X +: W_X];
            limit_q           <= (i_iter == '0) ? W_IT'(1) : i_iter;
            tol_q             <= i_tol;
            row_q             <= '0;
            sweep_q           <= '0;
            max_q             <= '0;
            o_iters           <= '0;
            o_converged       <= 1'b0;
            o_busy            <= 1'b1;
            core.o_core_valid <= 1'b1;
            state             <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (core.i_core_valid) begin
            x_q[row_q] <= core.i_core_x;
            max_q      <= max_next;
            if (row_q != 3'd7) begin
              row_q             <= row_q + 1'b1;
              core.o_core_valid <= 1'b1;
              state             <= S_ISSUE;
            end else begin
              sweep_q <= sweep_next;
              o_iters <= sweep_next;
              if (tol_q != '0 && max_next < tol_q) begin
                o_converged <= 1'b1;
                o_valid     <= 1'b1;
                o_x         <= x_final;
                state       <= S_DONE;
              end else if (sweep_next == limit_q) begin
                o_valid <= 1'b1;
                o_x     <= x_final;
                state   <= S_DONE;
              end else begin
                row_q             <= '0;
                max_q             <= '0;
                core.o_core_valid <= 1'b1;
                state             <= S_ISSUE;
              end
            end
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
